sr_cmd_debouncer: RTL and testbench
===================================

// Module: sr_cmd_debouncer
// PURPOSE
//   Upstream command stage for the edge-sensitive SR latch. Takes two raw, asynchronous,
//   bouncing push-button inputs (set and reset requests). It synchronises and debounces
//   them, then emits clean single-cycle s / r pulses. s and r are never high together,
//   so the downstream latch never sees the s=r=1 combination.
// PARAMETERS
//   DEBOUNCE_CYCLES  4  consecutive stable sync samples needed to qualify a press or release (>=1)
//   CNT_W            3  debounce counter width; DEBOUNCE_CYCLES <= 2**CNT_W
//   SET_WINS         0  arbitration on simultaneous qualification: 1 = s wins, 0 = r wins
// PORTS
//   clk       in   1  single clock, rising-edge
//   reset     in   1  asynchronous, active-low reset (0 = in reset)
//   set_btn   in   1  raw set request, asynchronous to clk, may bounce
//   rst_btn   in   1  raw reset request, asynchronous to clk, may bounce
//   s         out  1  registered 1-cycle set pulse to latch
//   r         out  1  registered 1-cycle reset pulse to latch
//   conflict  out  1  registered 1-cycle flag: both channels qualified on the same edge
// BEHAVIOUR
// - Reset (reset=0, async): all sync flops=0, both FSMs=IDLE, counters=0, s=r=conflict=0,
//   all immediately, with no clock required.
// - Synchroniser: 2-flop chain per input (sync1 -> sync2). The FSMs use sync2 only.
// - Per-channel FSM; D = DEBOUNCE_CYCLES:
//     IDLE : sync2=1 -> QUAL, cnt<=0. Otherwise stay in IDLE.
//     QUAL : sync2=0 -> IDLE, cnt<=0 (glitch rejected, no pulse).
//            sync2=1 and cnt==D-1 -> HELD, raise qualified event.
//            Otherwise cnt<=cnt+1.
//     HELD : sync2=0 -> REL, cnt<=0. Otherwise stay in HELD (no repeat pulses while held).
//     REL  : sync2=1 -> HELD, cnt<=0 (release bounce, no new pulse).
//            sync2=0 and cnt==D-1 -> IDLE.
//            Otherwise cnt<=cnt+1.
// - Output register, updated every edge:
//     only set event       -> s<=1, r<=0, conflict<=0
//     only reset event     -> r<=1, s<=0, conflict<=0
//     both on the same edge -> winner per SET_WINS <=1, loser <=0, conflict<=1.
//       The losing event is discarded; its FSM still enters HELD.
//     no event             -> s<=0, r<=0, conflict<=0
// - Latency: edge 0 is the first edge that samples raw=1. With the input held stable, the
//   pulse is high from edge D+2 to edge D+3 (D=4: edge 6). Width is exactly 1 cycle.
// - A new pulse on a channel requires the full cycle IDLE -> QUAL -> HELD -> REL -> IDLE -> QUAL.
// - Invariants: s & r == 0 always. conflict=1 implies exactly one of s / r is 1.
// - Reset mid-operation: any state or count is discarded. A button held across reset
//   deassertion is treated as a new press: pulse at edge D+2 after release.
// TESTING
//   (D=4 unless stated)
// 1. reset=0 with set_btn=rst_btn=1 for 5 cycles -> s=r=conflict=0 throughout.
//    Release reset with set_btn held -> s=1 for exactly the cycle after edge 6.
// 2. set_btn high for 20 cycles -> exactly one s pulse (edge 6), r=0.
//    Low 20 cycles, then high again -> second single s pulse, 6 edges after re-press.
// 3. set_btn high 3 cycles, then low -> no s pulse.
//    Toggling 1/0 every cycle for 30 cycles -> no pulse.
// 4. Held press (pulse seen), then set_btn low 2 cycles, high again -> no new pulse.
//    Low 10 cycles, high -> new pulse.
// 5. set_btn and rst_btn rise on the same cycle:
//    SET_WINS=0 -> r=1, s=0, conflict=1 for one cycle.
//    SET_WINS=1 -> s=1, r=0, conflict=1.
//    No later pulse from the loser while it is held.
// 6. rst_btn raised, reset pulled low at edge 4 for 2 cycles -> no r pulse during or after
//    reset until edge 6 counted from the first post-reset edge.
//    Same test with D=1 -> pulse at edge 3.

Source files
------------

// File: rtl/sr_cmd_debouncer.sv
// Command front end for the SR latch: sync, debounce and arbitrate
// two bouncing buttons into clean, mutually exclusive s / r pulses.
module sr_cmd_debouncer #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 3,
  parameter bit SET_WINS        = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic set_btn,
  input  logic rst_btn,
  output logic s,
  output logic r,
  output logic conflict
);

  typedef enum logic [1:0] {
    IDLE,
    QUAL,
    HELD,
    REL
  } st_t;

  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(DEBOUNCE_CYCLES - 1);

  // channel 0 = set, channel 1 = reset
  logic [1:0]       sync1;
  logic [1:0]       sync2;
  st_t              st_q  [2];
  st_t              st_d  [2];
  logic [CNT_W-1:0] cnt_q [2];
  logic [CNT_W-1:0] cnt_d [2];
  logic [1:0]       evt;
  logic             s_d;
  logic             r_d;
  logic             c_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {rst_btn, set_btn};
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        st_q[i]  <= IDLE;
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        st_q[i]  <= st_d[i];
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      st_d[i]  = st_q[i];
      cnt_d[i] = cnt_q[i];
      evt[i]   = 1'b0;
      unique case (st_q[i])
        IDLE: begin
          if (sync2[i]) begin
            st_d[i]  = QUAL;
            cnt_d[i] = '0;
          end
        end
        QUAL: begin
          if (!sync2[i]) begin
            st_d[i]  = IDLE;
            cnt_d[i] = '0;
          end else if (cnt_q[i] == LAST) begin
            st_d[i]  = HELD;
            cnt_d[i] = '0;
            evt[i]   = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
        HELD: begin
          if (!sync2[i]) begin
            st_d[i]  = REL;
            cnt_d[i] = '0;
          end
        end
        REL: begin
          if (sync2[i]) begin
            st_d[i]  = HELD;
            cnt_d[i] = '0;
          end else if (cnt_q[i] == LAST) begin
            st_d[i]  = IDLE;
            cnt_d[i] = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
        default: begin
          st_d[i]  = IDLE;
          cnt_d[i] = '0;
        end
      endcase
    end
  end

  // a losing event is dropped; its channel still sits in HELD
  always_comb begin
    s_d = 1'b0;
    r_d = 1'b0;
    c_d = 1'b0;
    unique case (1'b1)
      (evt == 2'b01): s_d = 1'b1;
      (evt == 2'b10): r_d = 1'b1;
      (evt == 2'b11): begin
        s_d = SET_WINS;
        r_d = !SET_WINS;
        c_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s        <= 1'b0;
      r        <= 1'b0;
      conflict <= 1'b0;
    end else begin
      s        <= s_d;
      r        <= r_d;
      conflict <= c_d;
    end
  end

endmodule

// File: tb/tb_sr_cmd_debouncer.sv
// Directed bench for sr_cmd_debouncer: three instances (D=4 r-wins,
// D=4 s-wins, D=1), each checked every cycle against a pulse queue.
module tb_sr_cmd_debouncer;

  typedef struct {
    int         at;
    logic [2:0] v;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int ecnt   = 0;
  int nchk   = 0;
  int nfail  = 0;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  logic a_reset, a_set, a_rst;
  logic b_reset, b_set, b_rst;
  logic c_reset, c_set, c_rst;
  logic a_s, a_r, a_c;
  logic b_s, b_r, b_c;
  logic c_s, c_r, c_c;

  sr_cmd_debouncer #(
    .DEBOUNCE_CYCLES(4), .CNT_W(3), .SET_WINS(1'b0)
  ) u_a (
    .clk(clk), .reset(a_reset),
    .set_btn(a_set), .rst_btn(a_rst),
    .s(a_s), .r(a_r), .conflict(a_c)
  );

  sr_cmd_debouncer #(
    .DEBOUNCE_CYCLES(4), .CNT_W(3), .SET_WINS(1'b1)
  ) u_b (
    .clk(clk), .reset(b_reset),
    .set_btn(b_set), .rst_btn(b_rst),
    .s(b_s), .r(b_r), .conflict(b_c)
  );

  sr_cmd_debouncer #(
    .DEBOUNCE_CYCLES(1), .CNT_W(3), .SET_WINS(1'b0)
  ) u_c (
    .clk(clk), .reset(c_reset),
    .set_btn(c_set), .rst_btn(c_rst),
    .s(c_s), .r(c_r), .conflict(c_c)
  );

  always @(posedge clk) ecnt <= ecnt + 1;

  // pulse expected dly edges after the first edge that samples the change
  task automatic push(input int i, input int dly,
                      input logic [2:0] v);
    exp_t e;
    e.at = ecnt + 1 + dly;
    e.v  = v;
    case (i)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_one(input int i, input logic [2:0] obs);
    logic [2:0] e;
    e = 3'b000;
    case (i)
      0: if (q0.size() > 0 && q0[0].at == ecnt)
           e = q0.pop_front().v;
      1: if (q1.size() > 0 && q1[0].at == ecnt)
           e = q1.pop_front().v;
      default: if (q2.size() > 0 && q2[0].at == ecnt)
           e = q2.pop_front().v;
    endcase
    nchk++;
    assert (obs === e) else begin
      nfail++;
      $error("FAIL out%0d edge %0d observed src=%b expected %b",
             i, ecnt, obs, e);
    end
    nchk++;
    assert (!(obs[2] & obs[1]) &&
            (!obs[0] || (obs[2] ^ obs[1]))) else begin
      nfail++;
      $error("FAIL inv%0d edge %0d observed src=%b expected legal",
             i, ecnt, obs);
    end
  endtask

  always @(negedge clk) begin
    check_one(0, {a_s, a_r, a_c});
    check_one(1, {b_s, b_r, b_c});
    check_one(2, {c_s, c_r, c_c});
  end

  initial begin
    a_reset = 1'b0; a_set = 1'b1; a_rst = 1'b1;
    b_reset = 1'b0; b_set = 1'b0; b_rst = 1'b0;
    c_reset = 1'b0; c_set = 1'b0; c_rst = 1'b0;
    #1;
    nchk++;
    assert ({a_s, a_r, a_c, b_s, b_r, b_c, c_s, c_r, c_c}
            === 9'b0) else begin
      nfail++;
      $error("FAIL async_reset observed %b expected 0",
             {a_s, a_r, a_c, b_s, b_r, b_c, c_s, c_r, c_c});
    end
    tick(5);
    b_reset = 1'b1;
    c_reset = 1'b1;

    // held set across reset release: treated as a new press
    a_rst = 1'b0;
    a_reset = 1'b1;
    push(0, 6, 3'b100);
    tick(20);
    a_set = 1'b0;
    tick(20);
    a_set = 1'b1;
    push(0, 6, 3'b100);
    tick(20);
    a_set = 1'b0;
    tick(20);

    // short press and chatter are rejected
    a_set = 1'b1;
    tick(3);
    a_set = 1'b0;
    tick(20);
    for (int k = 0; k < 30; k++) begin
      a_set = ~a_set;
      tick(1);
    end
    a_set = 1'b0;
    tick(20);

    // release bounce gives no repeat; full release re-arms
    a_set = 1'b1;
    push(0, 6, 3'b100);
    tick(20);
    a_set = 1'b0;
    tick(2);
    a_set = 1'b1;
    tick(20);
    a_set = 1'b0;
    tick(10);
    a_set = 1'b1;
    push(0, 6, 3'b100);
    tick(20);
    a_set = 1'b0;
    tick(20);

    // simultaneous qualification on both arbitration settings
    a_set = 1'b1; a_rst = 1'b1;
    b_set = 1'b1; b_rst = 1'b1;
    push(0, 6, 3'b011);
    push(1, 6, 3'b101);
    tick(30);
    a_set = 1'b0; a_rst = 1'b0;
    b_set = 1'b0; b_rst = 1'b0;
    tick(20);

    // reset mid-qualification discards progress
    a_rst = 1'b1;
    tick(4);
    a_reset = 1'b0;
    tick(2);
    a_reset = 1'b1;
    push(0, 6, 3'b010);
    tick(20);
    a_rst = 1'b0;
    tick(20);

    // D=1: plain press, then the reset-interrupted case
    c_set = 1'b1;
    push(2, 3, 3'b100);
    tick(10);
    c_set = 1'b0;
    tick(10);
    c_rst = 1'b1;
    tick(2);
    c_reset = 1'b0;
    tick(2);
    c_reset = 1'b1;
    push(2, 3, 3'b010);
    tick(10);
    c_rst = 1'b0;
    tick(10);

    nchk++;
    assert (q0.size() + q1.size() + q2.size() === 0) else begin
      nfail++;
      $error("FAIL pending observed %0d expected 0",
             q0.size() + q1.size() + q2.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

endmodule
